// File: rtl/csr_trap_ctrl.sv
`timescale 1ns/1ps
// csr_trap_ctrl -- sequences CSR read/write instructions, ECALL/EBREAK trap
// entry and MRET return into single-cycle CSR accesses on a shared port.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_op/csr/rs1/zimm/pc         request fields, latched on accept
//   stall                          pipeline freeze while a sequence runs
//   rd_we, rd_data                 rd writeback (old CSR value)
//   redirect, redirect_pc          one-cycle PC redirect
//   csr_w, csr_addr, csr_wdata     CSR file write/address port
//   csr_rdata                      CSR read data, combinational from csr_addr
module csr_trap_ctrl #(
  parameter logic [11:0] ADDR_MSTATUS = 12'h000,
  parameter logic [11:0] ADDR_MEPC    = 12'h041,
  parameter logic [11:0] ADDR_MCAUSE  = 12'h042,
  parameter logic [11:0] ADDR_MTVEC   = 12'h005
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_csr,
  input  logic [31:0] req_rs1,
  input  logic [4:0]  req_zimm,
  input  logic [31:0] req_pc,
  output logic        req_ready,
  output logic        stall,
  output logic        rd_we,
  output logic [31:0] rd_data,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        csr_w,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata
);

  localparam logic [2:0] OP_CSRRW  = 3'd1;
  localparam logic [2:0] OP_CSRRWI = 3'd2;
  localparam logic [2:0] OP_ECALL  = 3'd3;
  localparam logic [2:0] OP_EBREAK = 3'd4;
  localparam logic [2:0] OP_MRET   = 3'd5;

  typedef enum logic [2:0] {
    IDLE, RW, T_EPC, T_CAUSE, T_STAT, T_VEC, M_STAT, M_EPC
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [11:0] csr_q;
  logic [31:0] rs1_q;
  logic [4:0]  zimm_q;
  logic [31:0] pc_q;
  logic        accept;
  logic [31:0] mst_trap, mst_mret;

  assign req_ready = ~rst & (state_q == IDLE);
  assign stall     = ~rst & (state_q != IDLE);
  assign accept    = req_valid & req_ready;

  // mstatus update on trap entry: MPIE <- MIE, MIE <- 0
  always_comb begin
    mst_trap    = csr_rdata;
    mst_trap[7] = csr_rdata[3];
    mst_trap[3] = 1'b0;
  end

  // mstatus update on MRET: MIE <- MPIE, MPIE <- 1
  always_comb begin
    mst_mret    = csr_rdata;
    mst_mret[3] = csr_rdata[7];
    mst_mret[7] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_CSRRW, OP_CSRRWI: state_d = RW;
            OP_ECALL, OP_EBREAK: state_d = T_EPC;
            OP_MRET:             state_d = M_STAT;
            default:             state_d = IDLE;  // invalid op: consumed
          endcase
        end
      end
      RW:      state_d = IDLE;
      T_EPC:   state_d = T_CAUSE;
      T_CAUSE: state_d = T_STAT;
      T_STAT:  state_d = T_VEC;
      T_VEC:   state_d = IDLE;
      M_STAT:  state_d = M_EPC;
      M_EPC:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      csr_q   <= '0;
      rs1_q   <= '0;
      zimm_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= req_op;
        csr_q  <= req_csr;
        rs1_q  <= req_rs1;
        zimm_q <= req_zimm;
        pc_q   <= req_pc;
      end
    end
  end

  // Outputs are decoded from state rather than registered because several
  // depend on csr_rdata in the same cycle; everything is held at 0 in reset.
  always_comb begin
    csr_w       = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    rd_we       = 1'b0;
    rd_data     = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    if (!rst) begin
      case (state_q)
        RW: begin
          csr_w     = 1'b1;
          csr_addr  = csr_q;
          csr_wdata = (op_q == OP_CSRRWI) ? {27'b0, zimm_q} : rs1_q;
          rd_we     = 1'b1;
          rd_data   = csr_rdata;
        end
        T_EPC: begin
          csr_w     = 1'b1;
          csr_addr  = ADDR_MEPC;
          csr_wdata = pc_q;
        end
        T_CAUSE: begin
          csr_w     = 1'b1;
          csr_addr  = ADDR_MCAUSE;
          csr_wdata = (op_q == OP_ECALL) ? 32'd11 : 32'd3;
        end
        T_STAT: begin
          csr_w     = 1'b1;
          csr_addr  = ADDR_MSTATUS;
          csr_wdata = mst_trap;
        end
        T_VEC: begin
          csr_addr    = ADDR_MTVEC;
          redirect    = 1'b1;
          redirect_pc = {csr_rdata[31:2], 2'b00};
        end
        M_STAT: begin
          csr_w     = 1'b1;
          csr_addr  = ADDR_MSTATUS;
          csr_wdata = mst_mret;
        end
        M_EPC: begin
          csr_addr    = ADDR_MEPC;
          redirect    = 1'b1;
          redirect_pc = csr_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
`timescale 1ns/1ps
module tb_csr_trap_ctrl;

  localparam logic [11:0] A_MSTATUS = 12'h000;
  localparam logic [11:0] A_MEPC    = 12'h041;
  localparam logic [11:0] A_MCAUSE  = 12'h042;
  localparam logic [11:0] A_MTVEC   = 12'h005;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [11:0] req_csr;
  logic [31:0] req_rs1;
  logic [4:0]  req_zimm;
  logic [31:0] req_pc;
  logic        req_ready, stall, rd_we, redirect, csr_w;
  logic [31:0] rd_data, redirect_pc, csr_wdata, csr_rdata;
  logic [11:0] csr_addr;

  csr_trap_ctrl #(
    .ADDR_MSTATUS(A_MSTATUS),
    .ADDR_MEPC   (A_MEPC),
    .ADDR_MCAUSE (A_MCAUSE),
    .ADDR_MTVEC  (A_MTVEC)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_csr(req_csr), .req_rs1(req_rs1), .req_zimm(req_zimm), .req_pc(req_pc),
    .req_ready(req_ready), .stall(stall), .rd_we(rd_we), .rd_data(rd_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .csr_w(csr_w),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
  );

  always #5 clk = ~clk;

  // CSR file attached to the DUT, written by the DUT's own write port
  logic [31:0] csr_mem [4096] = '{default: '0};
  assign csr_rdata = csr_mem[csr_addr];
  always @(posedge clk) if (csr_w) csr_mem[csr_addr] <= csr_wdata;

  // Reference architectural CSR state, updated only by the model
  logic [31:0] ref_csr [4096] = '{default: '0};

  typedef struct {
    logic        w;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        rdwe;
    logic [31:0] rdd;
    logic        redir;
    logic [31:0] rpc;
  } step_t;
  step_t expq[$];

  int unsigned n_checks = 0, n_errors = 0;
  int unsigned stall_cur = 0, stall_last = 0, wr_cnt = 0, redir_cnt = 0;
  logic [31:0] last_rd_data = '0, last_redir_pc = '0;
  logic [4:0]  ctl;
  assign ctl = {stall, req_ready, csr_w, rd_we, redirect};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic step_t mk(input logic w, input logic [11:0] a, input logic [31:0] wd,
                               input logic rw, input logic [31:0] rd,
                               input logic rr, input logic [31:0] rp);
    step_t s;
    s.w = w; s.addr = a; s.wdata = wd; s.rdwe = rw; s.rdd = rd; s.redir = rr; s.rpc = rp;
    return s;
  endfunction

  // Architectural effect of one accepted instruction, as a list of cycles
  task automatic build_seq(input logic [2:0] op, input logic [11:0] csr, input logic [31:0] rs1,
                           input logic [4:0] zimm, input logic [31:0] pc);
    logic [31:0] st;
    case (op)
      3'd1: expq.push_back(mk(1, csr, rs1, 1, ref_csr[csr], 0, 0));
      3'd2: expq.push_back(mk(1, csr, {27'b0, zimm}, 1, ref_csr[csr], 0, 0));
      3'd3, 3'd4: begin
        st = ref_csr[A_MSTATUS];
        st = (st & ~32'h88) | (st[3] ? 32'h80 : 32'h0);
        expq.push_back(mk(1, A_MEPC, pc, 0, 0, 0, 0));
        expq.push_back(mk(1, A_MCAUSE, (op == 3'd3) ? 32'd11 : 32'd3, 0, 0, 0, 0));
        expq.push_back(mk(1, A_MSTATUS, st, 0, 0, 0, 0));
        expq.push_back(mk(0, A_MTVEC, 0, 0, 0, 1, ref_csr[A_MTVEC] & ~32'h3));
      end
      3'd5: begin
        st = ref_csr[A_MSTATUS];
        st = (st & ~32'h08) | 32'h80 | (st[7] ? 32'h08 : 32'h0);
        expq.push_back(mk(1, A_MSTATUS, st, 0, 0, 0, 0));
        expq.push_back(mk(0, A_MEPC, 0, 0, 0, 1, ref_csr[A_MEPC]));
      end
      default: ;
    endcase
  endtask

  // Per-cycle monitor: compare outputs against the model mid-cycle
  always @(negedge clk) begin
    step_t e;
    if (stall) stall_cur++;
    else if (stall_cur != 0) begin stall_last = stall_cur; stall_cur = 0; end
    if (csr_w) wr_cnt++;
    if (redirect) begin redir_cnt++; last_redir_pc = redirect_pc; end
    if (rd_we) last_rd_data = rd_data;
    if (rst) begin
      expq.delete();
      check_eq("rst_ctl", {27'b0, ctl}, 32'h0);
      check_eq("rst_addr", {20'b0, csr_addr}, 32'h0);
      check_eq("rst_data", csr_wdata | rd_data | redirect_pc, 32'h0);
    end else if (expq.size() != 0) begin
      e = expq.pop_front();
      check_eq("seq_ctl", {27'b0, ctl}, {27'b0, 1'b1, 1'b0, e.w, e.rdwe, e.redir});
      check_eq("seq_addr", {20'b0, csr_addr}, {20'b0, e.addr});
      check_eq("seq_wdata", csr_wdata, e.wdata);
      check_eq("seq_rd", rd_data, e.rdd);
      check_eq("seq_rpc", redirect_pc, e.rpc);
      if (e.w) ref_csr[e.addr] = e.wdata;
    end else begin
      check_eq("idle_ctl", {27'b0, ctl}, 32'h8);
      check_eq("idle_addr", {20'b0, csr_addr}, 32'h0);
      check_eq("idle_data", csr_wdata | rd_data | redirect_pc, 32'h0);
      if (req_valid) build_seq(req_op, req_csr, req_rs1, req_zimm, req_pc);
    end
  end

  // Called just after a rising edge; holds the request until accepted
  task automatic send(input logic [2:0] op, input logic [11:0] csr, input logic [31:0] rs1,
                      input logic [4:0] zimm, input logic [31:0] pc);
    logic ok;
    ok = 1'b0;
    req_valid = 1'b1; req_op = op; req_csr = csr; req_rs1 = rs1; req_zimm = zimm; req_pc = pc;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
    end
    if (!ok) check_eq("send_timeout", {31'b0, ok}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
    end
    if (!ok) check_eq("idle_timeout", {31'b0, ok}, 32'h1);
    @(posedge clk); #1;
  endtask

  function automatic logic [11:0] pick_csr();
    case ($urandom_range(0, 5))
      0: return A_MSTATUS;
      1: return A_MEPC;
      2: return A_MCAUSE;
      3: return A_MTVEC;
      4: return 12'h044;
      default: return 12'($urandom);
    endcase
  endfunction

  int unsigned wr_snap, redir_snap;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_csr = '0;
    req_rs1 = '0; req_zimm = '0; req_pc = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // CSRRW returns old mtvec
    send(3'd1, 12'h005, 32'h40, 5'd0, 32'h0);
    send(3'd1, 12'h005, 32'h80000100, 5'd0, 32'h0);
    wait_idle();
    check_eq("rw_old", last_rd_data, 32'h40);
    check_eq("rw_new", csr_mem[12'h005], 32'h80000100);
    check_eq("rw_stall", stall_last, 32'd1);

    // ECALL trap entry
    send(3'd1, A_MSTATUS, 32'h8, 5'd0, 32'h0);
    send(3'd1, A_MTVEC, 32'h203, 5'd0, 32'h0);
    wait_idle();
    send(3'd3, 12'h0, 32'h0, 5'd0, 32'h1000);
    wait_idle();
    check_eq("ecall_mepc", csr_mem[A_MEPC], 32'h1000);
    check_eq("ecall_mcause", csr_mem[A_MCAUSE], 32'd11);
    check_eq("ecall_mstatus", csr_mem[A_MSTATUS], 32'h80);
    check_eq("ecall_rpc", last_redir_pc, 32'h200);
    check_eq("ecall_stall", stall_last, 32'd4);

    // MRET
    send(3'd1, A_MEPC, 32'h1004, 5'd0, 32'h0);
    wait_idle();
    send(3'd5, 12'h0, 32'h0, 5'd0, 32'h0);
    wait_idle();
    check_eq("mret_mstatus", csr_mem[A_MSTATUS], 32'h88);
    check_eq("mret_rpc", last_redir_pc, 32'h1004);
    check_eq("mret_stall", stall_last, 32'd2);

    // CSRRWI with all-ones immediate, then EBREAK cause
    send(3'd2, 12'h044, 32'hFFFFFFFF, 5'h1F, 32'h0);
    wait_idle();
    check_eq("rwi_wdata", csr_mem[12'h044], 32'h1F);
    send(3'd4, 12'h0, 32'h0, 5'd0, 32'h2000);
    wait_idle();
    check_eq("ebreak_mcause", csr_mem[A_MCAUSE], 32'd3);

    // Reset during T_CAUSE aborts the trap
    send(3'd1, A_MCAUSE, 32'h55, 5'd0, 32'h0);
    send(3'd1, A_MSTATUS, 32'h8, 5'd0, 32'h0);
    wait_idle();
    redir_snap = redir_cnt;
    send(3'd3, 12'h0, 32'h0, 5'd0, 32'h3000);  // returns inside T_EPC
    @(posedge clk); #1 rst = 1'b1;              // T_CAUSE cycle
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_abort_ready", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_abort_mcause", csr_mem[A_MCAUSE], 32'h55);
    check_eq("rst_abort_mstatus", csr_mem[A_MSTATUS], 32'h8);
    check_eq("rst_abort_redir", redir_cnt, redir_snap);

    // Invalid op is consumed silently
    wr_snap = wr_cnt;
    redir_snap = redir_cnt;
    send(3'd7, 12'h005, 32'h1234, 5'd3, 32'h0);
    wait_idle();
    check_eq("inv_writes", wr_cnt, wr_snap);
    check_eq("inv_redir", redir_cnt, redir_snap);

    // Randomized traffic, including sporadic resets
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_op    = 3'($urandom_range(0, 7));
      req_csr   = pick_csr();
      req_rs1   = $urandom;
      req_zimm  = 5'($urandom);
      req_pc    = $urandom;
      @(posedge clk); #1;
    end
    rst = 1'b0; req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("end_mstatus", csr_mem[A_MSTATUS], ref_csr[A_MSTATUS]);
    check_eq("end_mepc", csr_mem[A_MEPC], ref_csr[A_MEPC]);
    check_eq("end_mcause", csr_mem[A_MCAUSE], ref_csr[A_MCAUSE]);
    check_eq("end_mtvec", csr_mem[A_MTVEC], ref_csr[A_MTVEC]);
    check_eq("end_044", csr_mem[12'h044], ref_csr[12'h044]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_trap_ctrl.md
CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_MSTATUS, 12'h000, mstatus address
- ADDR_MEPC, 12'h041, mepc address
- ADDR_MCAUSE, 12'h042, mcause address
- ADDR_MTVEC, 12'h005, mtvec address
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_op  in  3  1=CSRRW, 2=CSRRWI, 3=ECALL, 4=EBREAK, 5=MRET; others invalid
- req_csr  in  12  CSR address for CSRRW/CSRRWI
- req_rs1  in  32  rs1 value (CSRRW)
- req_zimm  in  5  immediate (CSRRWI)
- req_pc  in  32  PC of the requesting instruction
- req_ready  out  1  request accepted this cycle
- stall  out  1  freeze pipeline
- rd_we  out  1  rd write strobe
- rd_data  out  32  old CSR value for rd
- redirect  out  1  one-cycle PC redirect pulse
- redirect_pc  out  32  redirect target
- csr_w  out  1  CSR write enable
- csr_addr  out  12  CSR address
- csr_wdata  out  32  CSR write data
- csr_rdata  in  32  CSR read data, combinational from csr_addr

Function
REQ-003 States SHALL be: IDLE, RW, T_EPC, T_CAUSE, T_STAT, T_VEC, M_STAT, M_EPC.
REQ-004 req_ready SHALL be 1 only in IDLE; accept = req_valid & req_ready; on accept, req_op/csr/rs1/zimm/pc SHALL be latched.
REQ-005 Invalid req_op on accept SHALL be consumed with no state change and no outputs asserted.
REQ-006 stall SHALL equal (state != IDLE).
REQ-007 Accepted CSRRW/CSRRWI -> RW next cycle; then IDLE.
REQ-008 In RW: csr_addr=latched csr, csr_w=1, csr_wdata=rs1 (CSRRW) or {27'b0,zimm} (CSRRWI), rd_we=1, rd_data=csr_rdata (pre-write value, same cycle).
REQ-009 Accepted ECALL/EBREAK SHALL sequence T_EPC -> T_CAUSE -> T_STAT -> T_VEC -> IDLE, one cycle each.
REQ-010 T_EPC: csr_w=1, csr_addr=ADDR_MEPC, csr_wdata=latched pc.
REQ-011 T_CAUSE: csr_w=1, csr_addr=ADDR_MCAUSE, wdata=32'd11 (ECALL) or 32'd3 (EBREAK).
REQ-012 T_STAT: csr_addr=ADDR_MSTATUS, csr_w=1, wdata=csr_rdata with bit7 (MPIE)=csr_rdata[3], bit3 (MIE)=0, other bits unchanged.
REQ-013 T_VEC: csr_addr=ADDR_MTVEC, csr_w=0, redirect=1, redirect_pc={csr_rdata[31:2],2'b00}.
REQ-014 Accepted MRET SHALL sequence M_STAT -> M_EPC -> IDLE.
REQ-015 M_STAT: csr_addr=ADDR_MSTATUS, csr_w=1, wdata=csr_rdata with bit3=csr_rdata[7], bit7=1.
REQ-016 M_EPC: csr_addr=ADDR_MEPC, csr_w=0, redirect=1, redirect_pc=csr_rdata.
REQ-017 Outside the states named in REQ-008/010-016: csr_w=0, rd_we=0, redirect=0; csr_addr, csr_wdata, rd_data, redirect_pc=0.
REQ-018 Latency from accept: CSR op 1 cycle, trap 4 cycles (redirect on 4th), MRET 2 cycles (redirect on 2nd).
REQ-019 req_valid during a busy sequence SHALL be ignored (not accepted, not latched).

Reset
REQ-020 rst=1 at a clock edge SHALL force IDLE and clear all latched request fields.
REQ-021 While rst=1: csr_w=0, rd_we=0, redirect=0, stall=0, req_ready=0; all data outputs 0.
REQ-022 Reset mid-sequence SHALL abort it; no further CSR writes or redirect occur.

Verification
REQ-023 CSRRW csr=0x005, rs1=0x80000100, mtvec=0x40 -> next cycle csr_w=1, wdata=0x80000100, rd_we=1, rd_data=0x40; IDLE after.
REQ-024 ECALL pc=0x1000, mstatus=0x8, mtvec=0x203 -> writes mepc=0x1000, mcause=11, mstatus=0x80; redirect_pc=0x200 on 4th cycle; stall 4 cycles.
REQ-025 MRET with mstatus=0x80, mepc=0x1004 -> mstatus=0x88; redirect_pc=0x1004 on 2nd cycle.
REQ-026 CSRRWI zimm=5'h1F to 0x044 -> wdata=0x1F; EBREAK -> mcause=3.
REQ-027 rst asserted in T_CAUSE of ECALL -> no mcause/mstatus write, no redirect; req_ready=1 cycle after rst drops.
REQ-028 req_op=7 with req_valid=1 -> accepted, stall stays 0, no csr_w/rd_we/redirect.
